// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: one full-subtractor stage processes a-b-bin
// LSB first, one bit per clock, with an IDLE/RUN/DONE handshake.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic w_ai;
  logic w_bi;
  logic w_d;
  logic w_br_next;
  logic w_last;

  // Single full-subtractor stage on the current LSBs.
  assign w_ai      = r_a[0];
  assign w_bi      = r_b[0];
  assign w_d       = w_ai ^ w_bi ^ r_br;
  assign w_br_next = (~w_ai & w_bi) | (~w_ai & r_br) | (w_bi & r_br);
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Operand capture and serial datapath; result registers only load on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        ST_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_next;
          r_acc <= {w_d, r_acc[WIDTH-1:1]};
          if (w_last) begin
            r_diff <= {w_d, r_acc[WIDTH-1:1]};
            r_bout <= w_br_next;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (r_state == ST_IDLE);
  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);
  assign diff  = r_diff;
  assign bout  = r_bout;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl at WIDTH=8 and WIDTH=16: directed corner
// cases on the 8-bit instance, randomized traffic with resets on both.
module tb_serial_sub_ctrl;

  logic        clk;
  logic        rst8, start8, bin8;
  logic [7:0]  a8, b8;
  logic        rst16, start16, bin16;
  logic [15:0] a16, b16;
  wire         ready8, busy8, done8, bout8;
  wire  [7:0]  diff8;
  wire         ready16, busy16, done16, bout16;
  wire  [15:0] diff16;

  serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .ready(ready8), .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_sub_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst16), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .ready(ready16), .busy(busy16), .done(done16), .diff(diff16), .bout(bout16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks;
  int          n_fail;
  int          m_cnt   [2];
  logic [15:0] hold_d  [2];
  logic        hold_b  [2];
  bit          armed   [2];
  int          n_done  [2];
  logic [16:0] q0[$];
  logic [16:0] q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int g, input logic r, input logic s,
                       input logic [15:0] av, input logic [15:0] bv, input logic bi);
    if (g == 0) begin
      rst8 = r; start8 = s; a8 = av[7:0]; b8 = bv[7:0]; bin8 = bi;
    end else begin
      rst16 = r; start16 = s; a16 = av; b16 = bv; bin16 = bi;
    end
  endtask

  // Checks outputs against the reference state, then advances the reference
  // using the inputs that the coming rising edge will sample.
  task automatic monitor_step();
    for (int g = 0; g < 2; g++) begin
      int          w;
      logic [15:0] mask, a_s, b_s, d_s;
      logic        r_s, s_s, bi_s, rdy, bsy, dn, bo;
      logic [2:0]  exp_ctl;
      logic [16:0] ent;
      longint      av, bv, bi;
      int          qs;
      string       sfx;
      w    = (g == 0) ? 8 : 16;
      sfx  = (g == 0) ? "_w8" : "_w16";
      mask = 16'((32'd1 << w) - 32'd1);
      if (g == 0) begin
        a_s = {8'h00, a8}; b_s = {8'h00, b8}; d_s = {8'h00, diff8};
        r_s = rst8; s_s = start8; bi_s = bin8;
        rdy = ready8; bsy = busy8; dn = done8; bo = bout8;
        qs  = q0.size();
      end else begin
        a_s = a16; b_s = b16; d_s = diff16;
        r_s = rst16; s_s = start16; bi_s = bin16;
        rdy = ready16; bsy = busy16; dn = done16; bo = bout16;
        qs  = q1.size();
      end
      if (armed[g]) begin
        if (m_cnt[g] == 0)      exp_ctl = 3'b100;
        else if (m_cnt[g] <= w) exp_ctl = 3'b010;
        else                    exp_ctl = 3'b001;
        check({"ready_busy_done", sfx}, 32'({rdy, bsy, dn}), 32'(exp_ctl));
        if (dn) begin
          check({"sb_has_entry", sfx}, 32'(qs != 0), 32'd1);
          if (qs != 0) begin
            if (g == 0) ent = q0.pop_front();
            else        ent = q1.pop_front();
            hold_d[g] = ent[15:0];
            hold_b[g] = ent[16];
            n_done[g]++;
          end
        end
        check({"diff", sfx}, 32'(d_s), 32'(hold_d[g]));
        check({"bout", sfx}, 32'(bo), 32'(hold_b[g]));
      end
      if (r_s) begin
        m_cnt[g]  = 0;
        hold_d[g] = '0;
        hold_b[g] = 1'b0;
        armed[g]  = 1'b1;
        if (g == 0) q0.delete();
        else        q1.delete();
      end else if (m_cnt[g] == 0) begin
        if (s_s) begin
          av  = longint'(a_s);
          bv  = longint'(b_s);
          bi  = longint'(bi_s);
          ent = {(av < bv + bi), 16'(av - bv - bi) & mask};
          if (g == 0) q0.push_back(ent);
          else        q1.push_back(ent);
          m_cnt[g] = 1;
        end
      end else if (m_cnt[g] == w + 1) begin
        m_cnt[g] = 0;
      end else begin
        m_cnt[g]++;
      end
    end
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    tick();
    drive(0, 1'b0, 1'b1, {8'h00, av}, {8'h00, bv}, bi);
    tick();
    drive(0, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done8) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic rand_run(input int g, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      logic [15:0] ra, rb;
      tick();
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom);
      drive(g, $urandom_range(0, 599) == 0, $urandom_range(0, 3) != 0, ra, rb, 1'($urandom));
    end
    tick();
    drive(g, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic directed8();
    int         n, cnt, prev;
    logic [7:0] td;
    logic       tb_;
    op8(8'h5A, 8'h3C, 1'b0);
    wait_done8(n);
    check("latency_5a_3c", 32'(n), 32'd9);
    check("diff_5a_3c", 32'(diff8), 32'h1E);
    check("bout_5a_3c", 32'(bout8), 32'd0);

    op8(8'h00, 8'h01, 1'b0);
    wait_done8(n);
    check("diff_00_01", 32'(diff8), 32'hFF);
    check("bout_00_01", 32'(bout8), 32'd1);

    op8(8'hFF, 8'hFF, 1'b1);
    wait_done8(n);
    check("diff_ff_ff_1", 32'(diff8), 32'hFF);
    check("bout_ff_ff_1", 32'(bout8), 32'd1);

    // A start pulse while running must be ignored.
    op8(8'h5A, 8'h3C, 1'b0);
    repeat (3) tick();
    drive(0, 1'b0, 1'b1, 16'h0010, 16'h0001, 1'b0);
    tick();
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    cnt = 0; td = '0; tb_ = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8) begin
        cnt++; td = diff8; tb_ = bout8;
      end
    end
    check("ignored_start_done_count", 32'(cnt), 32'd1);
    check("ignored_start_diff", 32'(td), 32'h1E);
    check("ignored_start_bout", 32'(tb_), 32'd0);

    // Reset when the bit counter reads 4.
    op8(8'h5A, 8'h3C, 1'b0);
    repeat (4) tick();
    drive(0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    check("mid_rst_ready", 32'(ready8), 32'd1);
    check("mid_rst_busy", 32'(busy8), 32'd0);
    check("mid_rst_diff", 32'(diff8), 32'd0);
    check("mid_rst_bout", 32'(bout8), 32'd0);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8) cnt++;
    end
    check("mid_rst_no_done", 32'(cnt), 32'd0);
    op8(8'h5A, 8'h3C, 1'b0);
    wait_done8(n);
    check("post_rst_diff", 32'(diff8), 32'h1E);
    check("post_rst_bout", 32'(bout8), 32'd0);

    // Start held high: one operation every WIDTH+2 cycles.
    tick();
    drive(0, 1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
    cnt = 0; prev = -1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done8) begin
        if (prev >= 0) check("held_start_period", 32'(i - prev), 32'd10);
        prev = i;
        cnt++;
      end
      tick();
      drive(0, 1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
    end
    check("held_start_pulses", 32'(cnt >= 3), 32'd1);
    tick();
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (12) tick();
  endtask

  bit stop_mon;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    stop_mon = 1'b0;
    for (int g = 0; g < 2; g++) begin
      m_cnt[g] = 0; hold_d[g] = '0; hold_b[g] = 1'b0; armed[g] = 1'b0; n_done[g] = 0;
    end
    drive(0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    fork
      begin
        while (!stop_mon) begin
          @(negedge clk);
          monitor_step();
        end
      end
    join_none
    repeat (2) tick();
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    check("reset_ready_w8", 32'(ready8), 32'd1);
    check("reset_diff_w16", 32'(diff16), 32'd0);
    fork
      begin
        directed8();
        rand_run(0, 14000);
      end
      rand_run(1, 24000);
    join
    repeat (25) tick();
    check("ops_w8", 32'(n_done[0] >= 1000), 32'd1);
    check("ops_w16", 32'(n_done[1] >= 1000), 32'd1);
    check("drained_w8", 32'(q0.size()), 32'd0);
    check("drained_w16", 32'(q1.size()), 32'd0);
    stop_mon = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset: synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin a subtraction; sampled only when ready=1.
REQ-005 The block SHALL have port a, input, WIDTH bits, unsigned minuend; sampled with start.
REQ-006 The block SHALL have port b, input, WIDTH bits, unsigned subtrahend; sampled with start.
REQ-007 The block SHALL have port bin, input, 1 bit, borrow-in; sampled with start.
REQ-008 The block SHALL have port ready, output, 1 bit, high when a start will be accepted.
REQ-009 The block SHALL have port busy, output, 1 bit, high while bits are being processed.
REQ-010 The block SHALL have port done, output, 1 bit, single-cycle completion pulse.
REQ-011 The block SHALL have port diff, output, WIDTH bits, registered difference of the last completed operation.
REQ-012 The block SHALL have port bout, output, 1 bit, registered borrow-out of the last completed operation.

Function
REQ-013 The block SHALL compute the result bit-serially, LSB first, one bit per clk cycle, through a single 1-bit full-subtractor stage: d = ai^bi^br; br_next = (~ai&bi)|(~ai&br)|(bi&br).
REQ-014 The block SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-015 In IDLE: ready=1, busy=0, done=0; start=1 at an edge latches a, b, bin into internal shift/borrow registers, clears the bit counter, and moves to RUN.
REQ-016 In RUN: ready=0, busy=1; each edge processes bit index = counter, shifts the partial difference in, updates the borrow register, and increments the counter.
REQ-017 At the edge processing bit WIDTH-1, the block SHALL load diff with the full partial result, load bout with the final borrow, and move to DONE.
REQ-018 In DONE: done=1, busy=0, ready=0 for exactly one cycle, then unconditionally IDLE.
REQ-019 Latency SHALL be fixed: done is high during the cycle that follows WIDTH+1 rising edges after the edge accepting start. For WIDTH=8, this is 9 edges after the accepting edge.
REQ-020 Back-to-back throughput SHALL be one operation per WIDTH+2 cycles. Start is first re-accepted in the IDLE cycle after DONE.
REQ-021 Start, a, b and bin SHALL be ignored whenever ready=0 (RUN or DONE); latched operands SHALL NOT change mid-operation.
REQ-022 diff and bout SHALL be stable during RUN and hold the previous result until the next DONE; partial bits never appear on diff.
REQ-023 Arithmetic: diff = (a - b - bin) mod 2^WIDTH; bout = 1 iff a < b + bin (unsigned, evaluated at full precision).
REQ-024 The bit counter SHALL be ceil(log2(WIDTH)) bits, SHALL not wrap within an operation, and SHALL be cleared on each accepted start.
REQ-025 Outputs SHALL be driven only from registers or decode of FSM state; there are no combinational paths from inputs to outputs.

Reset
REQ-026 When rst=1 at an edge, the block SHALL enter IDLE, clear the counter, shift and borrow registers, and set diff=0, bout=0, done=0, busy=0; ready=1 from the following cycle.
REQ-027 rst SHALL take priority over start and over any in-progress operation; an interrupted operation SHALL produce no done pulse and SHALL leave diff=0 and bout=0.
REQ-028 After rst deasserts, the first start SHALL be accepted at the first edge with ready=1 and start=1.

Verification
REQ-029 The bench SHALL cover: WIDTH=8, a=0x5A, b=0x3C, bin=0 -> done 9 edges after accept, diff=0x1E, bout=0.
REQ-030 The bench SHALL cover: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; then a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
REQ-031 The bench SHALL cover: start pulsed with a=0x10, b=0x01 during RUN of a 0x5A-0x3C operation -> ignored; result remains 0x1E/0, and exactly one done pulse occurs.
REQ-032 The bench SHALL cover: rst=1 for one cycle mid-RUN (counter=4) -> no done pulse, diff=0, bout=0, ready=1 next cycle, and a new operation completes correctly.
REQ-033 The bench SHALL cover: start held high continuously -> operations accepted every 10 cycles (WIDTH=8), diff stable between done pulses.
REQ-034 The bench SHALL cover: random a, b, bin (at least 1000 operations, WIDTH=8 and WIDTH=16) checked against the REQ-023 reference model, asserting ready/busy/done mutually consistent every cycle.
